// File: rtl/params_pkg.sv
// params_pkg: shared widths, source count, arbiter state encoding and helpers.
package params_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int NUM_SRC = 4;
  typedef enum logic {IDLE, XFER} state_e;
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/rr_priority_encoder.sv
// rr_priority_encoder: picks the first requester at or after rr_ptr, wrapping.
module rr_priority_encoder #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  output logic [IW-1:0] winner,
  output logic          any_valid
);
  logic [IW-1:0] idx;
  always_comb begin
    winner = '0;
    idx = '0;
    any_valid = |req;
    // Scan from the farthest offset down so the nearest requester wins last.
    for (int k = N - 1; k >= 0; k--) begin
      idx = IW'((int'(rr_ptr) + k) % N);
      if (req[idx]) winner = idx;
    end
  end
endmodule

// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: packet-atomic round-robin merge of NUM_SRC AXI4-Stream sources.
module axis_rr_arbiter #(
  parameter int DATA_WIDTH = params_pkg::DATA_WIDTH,
  parameter int NUM_SRC = params_pkg::NUM_SRC,
  localparam int IW = $clog2(NUM_SRC)
) (
  input  logic                          axi_aclk,
  input  logic                          axi_resetn,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_SRC*4-1:0]          s_axis_tkeep,
  input  logic [NUM_SRC-1:0]            s_axis_tvalid,
  input  logic [NUM_SRC-1:0]            s_axis_tlast,
  output logic [NUM_SRC-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [3:0]                    m_axis_tkeep,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_tready,
  output logic [IW-1:0]                 grant_id,
  output logic                          busy,
  output logic [15:0]                   pkt_beats
);
  import params_pkg::*;
  state_e state_q, state_d;
  logic [IW-1:0] grant_q, grant_d, rr_ptr_q, rr_ptr_d, win;
  logic [15:0] cnt_q, cnt_d, pkt_beats_q, pkt_beats_d;
  logic any, xfer, beat;
  rr_priority_encoder #(.N(NUM_SRC)) u_pe (
    .req(s_axis_tvalid),
    .rr_ptr(rr_ptr_q),
    .winner(win),
    .any_valid(any)
  );
  assign xfer = state_q == XFER;
  assign grant_id = grant_q;
  assign busy = xfer;
  assign pkt_beats = pkt_beats_q;
  always_comb begin
    m_axis_tdata = s_axis_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
    m_axis_tkeep = s_axis_tkeep[grant_q*4 +: 4];
    m_axis_tvalid = xfer && s_axis_tvalid[grant_q];
    m_axis_tlast = xfer && s_axis_tlast[grant_q];
    s_axis_tready = xfer ? NUM_SRC'(m_axis_tready) << grant_q : '0;
    beat = m_axis_tvalid && m_axis_tready;
    state_d = state_q;
    grant_d = grant_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d = cnt_q;
    pkt_beats_d = pkt_beats_q;
    // IDLE spends exactly one cycle registering the winner before XFER.
    if (!xfer && any) begin
      state_d = XFER;
      grant_d = win;
      cnt_d = '0;
    end
    if (beat) begin
      cnt_d = sat_inc(cnt_q);
      if (m_axis_tlast) begin
        state_d = IDLE;
        rr_ptr_d = (grant_q == IW'(NUM_SRC - 1)) ? '0 : grant_q + 1'b1;
        pkt_beats_d = sat_inc(cnt_q);
        cnt_d = '0;
      end
    end
  end
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_ptr_q <= '0;
      cnt_q <= '0;
      pkt_beats_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q <= cnt_d;
      pkt_beats_q <= pkt_beats_d;
    end
  end
endmodule

// File: tb/tb_axis_rr_arbiter.sv
// tb_axis_rr_arbiter: directed scoreboard bench for the 4-source round-robin arbiter.
module tb_axis_rr_arbiter;
  localparam int N = 4;
  localparam int DW = 32;
  logic clk = 1'b0;
  logic axi_resetn;
  logic [N*DW-1:0] s_axis_tdata;
  logic [N*4-1:0] s_axis_tkeep;
  logic [N-1:0] s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [3:0] m_axis_tkeep;
  logic m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic [1:0] grant_id;
  logic busy;
  logic [15:0] pkt_beats;
  logic [DW-1:0] mem_d [N][64];
  logic mem_l [N][64];
  int wr [N] = '{default: 0};
  int rd [N] = '{default: 0};
  logic [N-1:0] hold = '0;
  logic [N-1:0] hs = '0;
  logic [38:0] sb [$];
  int compared = 0;
  int mismatched = 0;
  int beats_seen = 0;
  int b0, idle;

  always #5 clk = ~clk;

  axis_rr_arbiter dut (
    .axi_aclk(clk), .axi_resetn(axi_resetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .grant_id(grant_id), .busy(busy), .pkt_beats(pkt_beats)
  );

  always_comb begin
    s_axis_tdata = '0;
    s_axis_tkeep = '0;
    s_axis_tvalid = '0;
    s_axis_tlast = '0;
    for (int i = 0; i < N; i++) begin
      s_axis_tdata[i*DW +: DW] = mem_d[i][rd[i]];
      s_axis_tkeep[i*4 +: 4] = 4'(i + 1);
      s_axis_tlast[i] = mem_l[i][rd[i]];
      s_axis_tvalid[i] = (wr[i] != rd[i]) && !hold[i];
    end
  end

  always @(posedge clk)
    for (int i = 0; i < N; i++)
      if (hs[i] && axi_resetn) rd[i] <= rd[i] + 1;

  task automatic monitor();
    logic [38:0] exp, obs;
    forever begin
      @(negedge clk);
      hs = axi_resetn ? (s_axis_tvalid & s_axis_tready) : '0;
      if (axi_resetn && m_axis_tvalid && m_axis_tready) begin
        beats_seen++;
        exp = (sb.size() != 0) ? sb.pop_front() : 'x;
        obs = {grant_id, m_axis_tdata, m_axis_tkeep, m_axis_tlast};
        compared++;
        assert (obs === exp) else begin
          mismatched++;
          $error("FAIL beat got=%h exp=%h", obs, exp);
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int s, input int n, input int base);
    for (int k = 0; k < n; k++) begin
      mem_d[s][wr[s]] = 32'(base + k);
      mem_l[s][wr[s]] = (k == n - 1);
      sb.push_back({2'(s), 32'(base + k), 4'(s + 1), k == n - 1});
      wr[s]++;
    end
  endtask

  task automatic wait_grant(input logic [1:0] g);
    int c = 0;
    do begin
      @(negedge clk); #1;
      c++;
    end while (!(busy && grant_id == g) && c < 50);
    chk("grant", {29'd0, busy, grant_id}, {29'd0, 1'b1, g});
  endtask

  task automatic wait_beats(input int n);
    int c = 0;
    while (beats_seen - b0 < n && c < 50) begin
      @(negedge clk); #1;
      c++;
    end
    chk("beats", beats_seen - b0, n);
  endtask

  task automatic drain(input int budget);
    int c = 0;
    while (sb.size() != 0 && c < budget) begin
      @(negedge clk); #1;
      c++;
    end
    chk("drain_left", sb.size(), 0);
  endtask

  initial begin
    fork monitor(); join_none
    axi_resetn = 1'b0;
    m_axis_tready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_busy", busy, 0);
    chk("rst_mvalid", m_axis_tvalid, 0);
    chk("rst_mlast", m_axis_tlast, 0);
    chk("rst_sready", s_axis_tready, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_pkt", pkt_beats, 0);
    @(negedge clk) axi_resetn = 1'b1;
    // single 3-beat packet from src0
    @(posedge clk); #1;
    mem_d[0][wr[0]] = 32'h11; mem_l[0][wr[0]] = 1'b0; wr[0]++;
    mem_d[0][wr[0]] = 32'h22; mem_l[0][wr[0]] = 1'b0; wr[0]++;
    mem_d[0][wr[0]] = 32'h33; mem_l[0][wr[0]] = 1'b1; wr[0]++;
    sb.push_back({2'd0, 32'h11, 4'd1, 1'b0});
    sb.push_back({2'd0, 32'h22, 4'd1, 1'b0});
    sb.push_back({2'd0, 32'h33, 4'd1, 1'b1});
    @(negedge clk); #1;
    chk("bubble_busy", busy, 0);
    @(negedge clk); #1;
    chk("xfer_busy", busy, 1);
    chk("xfer_grant", grant_id, 0);
    drain(40);
    @(posedge clk); #1;
    chk("pkt3", pkt_beats, 3);
    chk("idle_after", busy, 0);
    @(negedge clk) axi_resetn = 1'b0;
    #1 chk("rst_pkt_clear", pkt_beats, 0);
    @(negedge clk) axi_resetn = 1'b1;
    // all four sources at once, rr_ptr = 0
    @(posedge clk); #1;
    for (int s = 0; s < N; s++) send(s, 2, (s << 4) + 1);
    idle = 0;
    for (int c = 0; c < 60 && sb.size() != 0; c++) begin
      @(negedge clk); #1;
      if (!busy) idle++;
    end
    chk("rr4_idle", idle, 4);
    chk("rr4_left", sb.size(), 0);
    @(posedge clk); #1;
    chk("pkt2", pkt_beats, 2);
    // pointer must have wrapped to 0: src1 beats src3
    send(1, 1, 'hA0);
    send(3, 1, 'hB0);
    drain(40);
    // src2 packet with downstream stalls while src1 waits
    @(posedge clk); #1;
    b0 = beats_seen;
    for (int k = 0; k < 5; k++) begin
      mem_d[2][wr[2]] = 32'h21 + k; mem_l[2][wr[2]] = (k == 4); wr[2]++;
      sb.push_back({2'd2, 32'h21 + k, 4'd3, k == 4});
    end
    wait_grant(2);
    send(1, 2, 'hC1);
    wait_beats(2);
    @(posedge clk);
    @(posedge clk); #1;
    m_axis_tready = 1'b0;
    @(negedge clk); #1;
    chk("stall_data0", m_axis_tdata, 32'h24);
    chk("stall_sready", s_axis_tready, 0);
    @(negedge clk); #1;
    chk("stall_data1", m_axis_tdata, 32'h24);
    chk("stall_grant", grant_id, 2);
    @(posedge clk); #1;
    m_axis_tready = 1'b1;
    drain(60);
    // src1 stalls its own valid; ownership must hold
    @(posedge clk); #1;
    b0 = beats_seen;
    send(1, 4, 'h31);
    wait_grant(1);
    send(3, 2, 'hD1);
    wait_beats(2);
    @(posedge clk); #1;
    hold[1] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      chk("hold_busy", busy, 1);
      chk("hold_grant", grant_id, 1);
    end
    @(posedge clk); #1;
    hold[1] = 1'b0;
    drain(60);
    @(posedge clk); #1;
    chk("pkt_src3", pkt_beats, 2);
    // reset in the middle of an 8-beat src2 packet
    b0 = beats_seen;
    send(2, 8, 'h41);
    wait_grant(2);
    wait_beats(2);
    @(posedge clk);
    @(negedge clk); #2;
    axi_resetn = 1'b0;
    #1;
    chk("mid_rst_mvalid", m_axis_tvalid, 0);
    chk("mid_rst_sready", s_axis_tready, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_pkt", pkt_beats, 0);
    sb.delete();
    for (int s = 0; s < N; s++) wr[s] = rd[s];
    @(posedge clk);
    @(negedge clk) axi_resetn = 1'b1;
    @(posedge clk); #1;
    send(0, 2, 'h51);
    send(2, 2, 'h61);
    wait_grant(0);
    drain(60);
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
